// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port word memory.
// Each transaction runs IDLE (grant) -> ACCESS (memory cycle) -> RESP (done).
module mem_arbiter #(
    parameter int SIZE = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        we_a,
    input  logic        we_b,
    input  logic [31:0] adr_a,
    input  logic [31:0] adr_b,
    input  logic [31:0] wd_a,
    input  logic [31:0] wd_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        done_a,
    output logic        done_b,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [29:0] SIZE_W = 30'(SIZE);

    state_t      state_q;
    logic        last_b_q;   // 1 = B was granted most recently
    logic        id_q;       // requester of the in-flight transaction, 1 = B
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] wd_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        done_a_q;
    logic        done_b_q;

    logic        pick_a_d;
    logic        pick_b_d;
    logic        in_range;
    logic [31:0] rdata_d;

    // Grant decision: only in IDLE and never while reset is held; ties go to
    // whoever did not win last time.
    always_comb begin
        pick_a_d = 1'b0;
        pick_b_d = 1'b0;
        if (!reset && state_q == IDLE) begin
            if (req_a && (!req_b || last_b_q)) begin
                pick_a_d = 1'b1;
            end else if (req_b) begin
                pick_b_d = 1'b1;
            end
        end
    end

    // Range check and response data for the latched access; byte offset bits
    // take no part in either.
    always_comb begin
        in_range = (adr_q[31:2] < SIZE_W);
        rdata_d  = (!we_q && in_range) ? mem_rd : 32'h0;
    end

    assign gnt_a   = pick_a_d;
    assign gnt_b   = pick_b_d;
    assign done_a  = done_a_q;
    assign done_b  = done_b_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign mem_adr = adr_q;
    assign mem_wd  = wd_q;
    // Decoded from state so an asynchronous reset kills the strobe at once.
    assign mem_we  = (state_q == ACCESS) && we_q && in_range;

    // Transaction FSM with latched request and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= 32'h0;
            wd_q     <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_a_d || pick_b_d) begin
                        id_q     <= pick_b_d;
                        last_b_q <= pick_b_d;
                        we_q     <= pick_b_d ? we_b  : we_a;
                        adr_q    <= pick_b_d ? adr_b : adr_a;
                        wd_q     <= pick_b_d ? wd_b  : wd_a;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata_q  <= rdata_d;
                    err_q    <= !in_range;
                    done_a_q <= !id_q;
                    done_b_q <= id_q;
                    state_q  <= RESP;
                end
                RESP: begin
                    err_q    <= 1'b0;
                    done_a_q <= 1'b0;
                    done_b_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 64-word memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b, we_a, we_b;
    logic [31:0] adr_a, adr_b, wd_a, wd_b;
    logic        gnt_a, gnt_b, done_a, done_b, err, mem_we;
    logic [31:0] rdata, mem_adr, mem_wd, mem_rd;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model, preload port and write monitors.
    logic [31:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_dat = 32'h0;
    int          we_cnt = 0;
    int          oor_cnt = 0;
    logic [29:0] widx;

    assign widx   = mem_adr[31:2];
    assign mem_rd = (widx < 30'd64) ? mem[widx[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_dat;
        if (mem_we) begin
            we_cnt <= we_cnt + 1;
            if (widx < 30'd64) mem[widx[5:0]] <= mem_wd;
            else oor_cnt <= oor_cnt + 1;
        end
    end

    always #5 clk = ~clk;

    mem_arbiter #(.SIZE(64)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .adr_a(adr_a), .adr_b(adr_b), .wd_a(wd_a), .wd_b(wd_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .rdata(rdata), .err(err), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] dat);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_dat = dat;
        cyc();
        pl_en  = 1'b0;
    endtask

    // One isolated transaction starting in IDLE; ends in its RESP cycle.
    task automatic txn(input bit sel_b, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit exp_we,
                       input logic [31:0] exp_rd, input bit exp_err);
        cyc();
        if (sel_b) begin req_b = 1; we_b = w; adr_b = a; wd_b = d; end
        else       begin req_a = 1; we_a = w; adr_a = a; wd_a = d; end
        #1;
        chk("gnt_a_idle", 32'(gnt_a), 32'(!sel_b));
        chk("gnt_b_idle", 32'(gnt_b), 32'(sel_b));
        chk("done_idle", 32'(done_a | done_b), 32'd0);
        chk("err_idle", 32'(err), 32'd0);
        cyc();
        req_a = 0; req_b = 0;
        #1;
        chk("gnt_access", 32'(gnt_a | gnt_b), 32'd0);
        chk("mem_we_access", 32'(mem_we), 32'(exp_we));
        chk("mem_adr_access", mem_adr, a);
        chk("mem_wd_access", mem_wd, d);
        cyc();
        #1;
        chk("done_a_resp", 32'(done_a), 32'(!sel_b));
        chk("done_b_resp", 32'(done_b), 32'(sel_b));
        chk("rdata_resp", rdata, exp_rd);
        chk("err_resp", 32'(err), 32'(exp_err));
        chk("mem_we_resp", 32'(mem_we), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_snap, oor_snap;
        logic [31:0] m0_snap;
        bit a_turn;

        reset = 1;
        req_a = 1; req_b = 0; we_a = 0; we_b = 0;
        adr_a = 32'h14; adr_b = 0; wd_a = 0; wd_b = 0;
        preload(6'd5, 32'hDEADBEEF);
        preload(6'd3, 32'h33333333);
        preload(6'd0, 32'h0BADF00D);
        preload(6'd63, 32'h0);
        // Reset state with a request pending
        #1;
        chk("rst_gnt_a", 32'(gnt_a), 32'd0);
        chk("rst_gnt_b", 32'(gnt_b), 32'd0);
        chk("rst_done", 32'(done_a | done_b), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_adr", mem_adr, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        req_a = 0;
        @(negedge clk) reset = 0;

        // Single read of word 5
        txn(0, 0, 32'h14, 32'h0, 0, 32'hDEADBEEF, 0);
        // B writes word 8, then reads it back with nonzero byte offset
        txn(1, 1, 32'h20, 32'h12345678, 1, 32'h0, 0);
        txn(1, 0, 32'h23, 32'h0, 0, 32'h12345678, 0);
        chk("mem8_written", mem[8], 32'h12345678);
        // Highest in-range word, offset bits ignored
        txn(0, 1, 32'hFE, 32'hCAFEF00D, 1, 32'h0, 0);
        txn(1, 0, 32'hFD, 32'h0, 0, 32'hCAFEF00D, 0);
        chk("mem63_written", mem[63], 32'hCAFEF00D);
        // Out-of-range write and read (word 64)
        we_snap = we_cnt; oor_snap = oor_cnt; m0_snap = mem[0];
        txn(0, 1, 32'h100, 32'hFFFFFFFF, 0, 32'h0, 1);
        txn(0, 0, 32'h100, 32'h0, 0, 32'h0, 1);
        chk("oor_no_we", 32'(we_cnt - we_snap), 32'd0);
        chk("oor_no_write", 32'(oor_cnt - oor_snap), 32'd0);
        chk("oor_mem0", mem[0], m0_snap);

        // Continuous contention right after reset: A, B, A, B every 3 cycles
        cyc();
        @(negedge clk) reset = 1;
        @(negedge clk) reset = 0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (c == 0) begin
                req_a = 1; we_a = 0; adr_a = 32'h14;
                req_b = 1; we_b = 0; adr_b = 32'h20;
            end
            #1;
            a_turn = ((c / 3) % 2) == 0;
            chk($sformatf("cont_gnt_a_c%0d", c), 32'(gnt_a), 32'((c % 3 == 0) && a_turn));
            chk($sformatf("cont_gnt_b_c%0d", c), 32'(gnt_b), 32'((c % 3 == 0) && !a_turn));
            chk($sformatf("cont_done_a_c%0d", c), 32'(done_a), 32'((c % 3 == 2) && a_turn));
            chk($sformatf("cont_done_b_c%0d", c), 32'(done_b), 32'((c % 3 == 2) && !a_turn));
            if (c % 3 == 2)
                chk($sformatf("cont_rdata_c%0d", c), rdata, a_turn ? 32'hDEADBEEF : 32'h12345678);
        end
        req_a = 0; req_b = 0;

        // Reset during the ACCESS cycle of an A write to word 3
        cyc();
        req_a = 1; we_a = 1; adr_a = 32'h0C; wd_a = 32'hAAAA5555;
        #1;
        chk("rstacc_gnt_a", 32'(gnt_a), 32'd1);
        cyc();
        req_a = 0; we_a = 0;
        #1;
        chk("rstacc_we_before", 32'(mem_we), 32'd1);
        #1 reset = 1;
        #1;
        chk("rstacc_we_dropped", 32'(mem_we), 32'd0);
        chk("rstacc_rdata", rdata, 32'h0);
        chk("rstacc_mem_adr", mem_adr, 32'h0);
        cyc();
        chk("rstacc_no_done", 32'(done_a | done_b), 32'd0);
        chk("rstacc_mem3", mem[3], 32'h33333333);
        @(negedge clk) reset = 0;

        // Contention after reset goes to A again
        cyc();
        req_a = 1; we_a = 0; adr_a = 32'h14;
        req_b = 1; we_b = 0; adr_b = 32'h20;
        #1;
        chk("post_rst_gnt_a", 32'(gnt_a), 32'd1);
        chk("post_rst_gnt_b", 32'(gnt_b), 32'd0);
        cyc();
        req_a = 0; req_b = 0;
        cyc();
        #1;
        chk("post_rst_done_a", 32'(done_a), 32'd1);
        chk("post_rst_rdata", rdata, 32'hDEADBEEF);

        // Late request: B rises during ACCESS of an A read
        cyc();
        req_a = 1; adr_a = 32'h14;
        #1;
        chk("late_gnt_a", 32'(gnt_a), 32'd1);
        cyc();
        req_a = 0; req_b = 1; adr_b = 32'h20;
        #1;
        chk("late_gnt_b_access", 32'(gnt_b), 32'd0);
        cyc();
        #1;
        chk("late_gnt_b_resp", 32'(gnt_b), 32'd0);
        chk("late_done_a", 32'(done_a), 32'd1);
        cyc();
        #1;
        chk("late_gnt_b_idle", 32'(gnt_b), 32'd1);
        cyc();
        req_b = 0;
        cyc();
        #1;
        chk("late_done_b", 32'(done_b), 32'd1);
        chk("late_rdata_b", rdata, 32'h12345678);
        cyc();
        #1;
        chk("late_done_clear", 32'(done_a | done_b), 32'd0);
        chk("rdata_holds", rdata, 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
